vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 154 +++++++++++++++
 tb/tb_vram_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch > host access > bulk clear, one slot per cycle.
// Memory bus is registered; reads return through a two-stage tag pipeline.
module vram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int STARVE_LIM = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_starved,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] H_IDLE = 2'd0;
    localparam logic [1:0] H_PEND = 2'd1;
    localparam logic [1:0] H_BUSY = 2'd2;

    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_DISP = 2'd1;
    localparam logic [1:0] T_HRD  = 2'd2;

    localparam logic [7:0]      STARVE_LIM_8 = 8'(STARVE_LIM);
    localparam logic [ADDR_W:0] PTR_ONE      = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        r_hstate;
    logic [1:0]        r_tag1;
    logic [1:0]        r_tag2;
    logic              r_disp_valid;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_host_ack;
    logic [DATA_W-1:0] r_host_rdata;
    logic [7:0]        r_starve_cnt;
    logic              r_clr_busy;
    logic [DATA_W-1:0] r_clr_val;
    logic [ADDR_W:0]   r_clr_ptr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_host_elig;
    logic              w_gnt_disp;
    logic              w_gnt_host;
    logic              w_gnt_clr;
    logic [ADDR_W:0]   w_clr_ptr_next;

    // While BUSY (including the ack cycle) the host is not eligible for a new grant.
    assign w_host_elig    = host_req && (r_hstate != H_BUSY);
    assign w_gnt_disp     = disp_req;
    assign w_gnt_host     = !disp_req && w_host_elig;
    assign w_gnt_clr      = !disp_req && !w_host_elig && r_clr_busy;
    assign w_clr_ptr_next = r_clr_ptr + PTR_ONE;

    assign disp_valid   = r_disp_valid;
    assign disp_data    = r_disp_data;
    assign host_ack     = r_host_ack;
    assign host_rdata   = r_host_rdata;
    assign host_starved = (r_starve_cnt >= STARVE_LIM_8);
    assign clr_busy     = r_clr_busy;
    assign mem_addr     = r_mem_addr;
    assign mem_we       = r_mem_we;
    assign mem_wdata    = r_mem_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_tag1       <= T_NONE;
            r_tag2       <= T_NONE;
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
            r_host_rdata <= '0;
            r_host_ack   <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_gnt_disp) begin
                r_mem_addr <= disp_addr;
            end else if (w_gnt_host) begin
                r_mem_addr <= host_addr;
                r_mem_we   <= host_we;
                if (host_we)
                    r_mem_wdata <= host_wdata;
            end else if (w_gnt_clr) begin
                r_mem_addr  <= r_clr_ptr[ADDR_W-1:0];
                r_mem_we    <= 1'b1;
                r_mem_wdata <= r_clr_val;
            end
            r_tag1 <= w_gnt_disp ? T_DISP : ((w_gnt_host && !host_we) ? T_HRD : T_NONE);
            r_tag2 <= r_tag1;
            r_disp_valid <= (r_tag2 == T_DISP);
            if (r_tag2 == T_DISP)
                r_disp_data <= mem_rdata;
            if (r_tag2 == T_HRD)
                r_host_rdata <= mem_rdata;
            // Writes ack alongside the bus write; reads ack with the returned data.
            r_host_ack <= (w_gnt_host && host_we) || (r_tag2 == T_HRD);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hstate     <= H_IDLE;
            r_starve_cnt <= '0;
        end else begin
            if (w_gnt_host)
                r_starve_cnt <= '0;
            else if (w_host_elig && (r_starve_cnt != 8'hFF))
                r_starve_cnt <= r_starve_cnt + 8'd1;
            case (r_hstate)
                H_IDLE:  if (w_gnt_host) r_hstate <= H_BUSY;
                         else if (host_req) r_hstate <= H_PEND;
                H_PEND:  if (w_gnt_host) r_hstate <= H_BUSY;
                H_BUSY:  if (r_host_ack) r_hstate <= H_IDLE;
                default: r_hstate <= H_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_busy <= 1'b0;
            r_clr_val  <= '0;
            r_clr_ptr  <= '0;
        end else if (!r_clr_busy) begin
            if (clr_start) begin
                r_clr_busy <= 1'b1;
                r_clr_val  <= clr_value;
                r_clr_ptr  <= '0;
            end
        end else if (w_gnt_clr) begin
            r_clr_ptr <= w_clr_ptr_next;
            // The extra pointer bit flags that the last address has just been issued.
            if (w_clr_ptr_next[ADDR_W])
                r_clr_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered-read RAM model on the memory port.
module tb_vram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       disp_req;
    logic [9:0] disp_addr;
    logic       disp_valid;
    logic [7:0] disp_data;
    logic       host_req;
    logic       host_we;
    logic [9:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       host_starved;
    logic       clr_start;
    logic [7:0] clr_value;
    logic       clr_busy;
    logic [9:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic       ld_en;
    logic [9:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] ram [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en)
            ram[ld_addr] <= ld_data;
        else if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    vram_arbiter #(.ADDR_W(10), .DATA_W(8), .STARVE_LIM(64)) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_starved(host_starved),
        .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL reset_disp_valid got %b want 0", disp_valid); end
        checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL reset_host_ack got %b want 0", host_ack); end
        checks++; if (host_starved !== 1'b0) begin failures++; $display("FAIL reset_host_starved got %b want 0", host_starved); end
        checks++; if (clr_busy !== 1'b0) begin failures++; $display("FAIL reset_clr_busy got %b want 0", clr_busy); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 10'h000) begin failures++; $display("FAIL reset_mem_addr got %h want 000", mem_addr); end
        $display("reset: outputs checked");
    endtask

    task automatic test_display_burst();
        logic [7:0] exp_d;
        logic       exp_v;
        for (int c = 0; c < 12; c++) begin
            disp_req  = (c < 8);
            disp_addr = 10'(c);
            step();
            exp_v = (c >= 2) && (c < 10);
            exp_d = 8'(c - 2) ^ 8'h5A;
            checks++;
            if (disp_valid !== exp_v) begin
                failures++; $display("FAIL burst_valid cycle %0d got %b want %b", c + 1, disp_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (disp_data !== exp_d) begin
                    failures++; $display("FAIL burst_data cycle %0d got %h want %h", c + 1, disp_data, exp_d);
                end
            end
            $display("burst cycle %0d: valid=%b data=%h", c + 1, disp_valid, disp_data);
        end
        disp_req = 1'b0;
    endtask

    task automatic test_display_pattern();
        logic [7:0] pat;
        logic       exp_v;
        int         k;
        pat = 8'b0100_1101;  // bit c = request in cycle c: 1,0,1,1,0,0,1,0
        for (int c = 0; c < 12; c++) begin
            disp_req  = (c < 8) ? pat[c] : 1'b0;
            disp_addr = 10'(c);
            step();
            k = c - 2;
            exp_v = (k >= 0 && k < 8) ? pat[k] : 1'b0;
            checks++;
            if (disp_valid !== exp_v) begin
                failures++; $display("FAIL pattern_valid cycle %0d got %b want %b", c + 1, disp_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (disp_data !== (8'(k) ^ 8'h5A)) begin
                    failures++; $display("FAIL pattern_data cycle %0d got %h want %h", c + 1, disp_data, 8'(k) ^ 8'h5A);
                end
            end
            $display("pattern cycle %0d: valid=%b data=%h", c + 1, disp_valid, disp_data);
        end
        disp_req = 1'b0;
    endtask

    task automatic test_host_rw();
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'h3FF; host_wdata = 8'hC3;
        step();
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL hw_mem_we got %b want 1", mem_we); end
        checks++; if (mem_addr !== 10'h3FF) begin failures++; $display("FAIL hw_mem_addr got %h want 3ff", mem_addr); end
        checks++; if (mem_wdata !== 8'hC3) begin failures++; $display("FAIL hw_mem_wdata got %h want c3", mem_wdata); end
        checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL hw_ack got %b want 1", host_ack); end
        $display("host write: we=%b addr=%h data=%h ack=%b", mem_we, mem_addr, mem_wdata, host_ack);
        host_req = 1'b0;
        step();
        checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL hw_ack_pulse got %b want 0", host_ack); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 10'h3FF) begin
            failures++; $display("FAIL idle_bus got we=%b addr=%h want we=0 addr=3ff", mem_we, mem_addr);
        end
        host_req = 1'b1; host_we = 1'b0;
        step();
        checks++; if (mem_we !== 1'b0 || mem_addr !== 10'h3FF) begin
            failures++; $display("FAIL hr_bus got we=%b addr=%h want we=0 addr=3ff", mem_we, mem_addr);
        end
        checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL hr_ack_early1 got %b want 0", host_ack); end
        step();
        checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL hr_ack_early2 got %b want 0", host_ack); end
        step();
        checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL hr_ack got %b want 1", host_ack); end
        checks++; if (host_rdata !== 8'hC3) begin failures++; $display("FAIL hr_rdata got %h want c3", host_rdata); end
        $display("host read: ack=%b rdata=%h", host_ack, host_rdata);
        host_req = 1'b0;
        step();
        checks++; if (host_ack !== 1'b0 || host_rdata !== 8'hC3) begin
            failures++; $display("FAIL hr_hold got ack=%b rdata=%h want ack=0 rdata=c3", host_ack, host_rdata);
        end
    endtask

    task automatic test_starve();
        logic exp_s;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h3FF;
        for (int c = 0; c <= 70; c++) begin
            disp_req  = (c < 70);
            disp_addr = 10'(c & 7);
            step();
            exp_s = (c + 1 >= 64) && (c < 70);
            checks++;
            if (host_starved !== exp_s || host_ack !== 1'b0) begin
                failures++; $display("FAIL starve cycle %0d got starved=%b ack=%b want starved=%b ack=0", c + 1, host_starved, host_ack, exp_s);
            end
            $display("starve cycle %0d: starved=%b", c + 1, host_starved);
        end
        checks++; if (mem_addr !== 10'h3FF || mem_we !== 1'b0) begin
            failures++; $display("FAIL starve_grant got addr=%h we=%b want addr=3ff we=0", mem_addr, mem_we);
        end
        step();
        checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL starve_ack_early got %b want 0", host_ack); end
        step();
        checks++; if (host_ack !== 1'b1 || host_rdata !== 8'hC3) begin
            failures++; $display("FAIL starve_ack got ack=%b rdata=%h want ack=1 rdata=c3", host_ack, host_rdata);
        end
        $display("starve read: ack=%b rdata=%h", host_ack, host_rdata);
        host_req = 1'b0;
        step();
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        int wr_cnt   = 0;
        int bad      = 0;
        int nonzero  = 0;
        clr_value = 8'h00; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 1030; i++) begin
            if (clr_busy === 1'b1) busy_cnt++;
            if (mem_we === 1'b1) begin
                if (mem_addr !== 10'(wr_cnt) || mem_wdata !== 8'h00) bad++;
                wr_cnt++;
            end
            clr_start = (i == 500);
            clr_value = (i == 500) ? 8'hFF : 8'h00;
            step();
        end
        clr_start = 1'b0;
        step();
        for (int a = 0; a < 1024; a++) if (ram[a] !== 8'h00) nonzero++;
        checks++; if (busy_cnt != 1024) begin failures++; $display("FAIL clr_busy_cycles got %0d want 1024", busy_cnt); end
        checks++; if (wr_cnt != 1024) begin failures++; $display("FAIL clr_writes got %0d want 1024", wr_cnt); end
        checks++; if (bad != 0) begin failures++; $display("FAIL clr_write_order got %0d bad want 0", bad); end
        checks++; if (nonzero != 0) begin failures++; $display("FAIL clr_ram got %0d nonzero want 0", nonzero); end
        checks++; if (clr_busy !== 1'b0) begin failures++; $display("FAIL clr_done got %b want 0", clr_busy); end
        $display("clear: busy=%0d writes=%0d bad=%0d nonzero=%0d", busy_cnt, wr_cnt, bad, nonzero);
    endtask

    task automatic test_reset_mid();
        ld_en = 1'b1; ld_addr = 10'h005; ld_data = 8'h99;
        step();
        ld_en = 1'b0;
        disp_req = 1'b1; disp_addr = 10'h005;
        step();
        disp_req = 1'b0;
        step();
        clr_value = 8'h77; clr_start = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h005;
        step();
        clr_start = 1'b0;
        step();
        checks++; if (clr_busy !== 1'b1) begin failures++; $display("FAIL mid_clr_active got %b want 1", clr_busy); end
        #1 reset = 1'b1;
        #1;
        checks++; if (disp_valid !== 1'b0 || host_ack !== 1'b0 || host_starved !== 1'b0 || clr_busy !== 1'b0 || mem_we !== 1'b0) begin
            failures++; $display("FAIL async_flags got dv=%b ack=%b st=%b busy=%b we=%b want all 0", disp_valid, host_ack, host_starved, clr_busy, mem_we);
        end
        checks++; if (disp_data !== 8'h00 || host_rdata !== 8'h00 || mem_addr !== 10'h000 || mem_wdata !== 8'h00) begin
            failures++; $display("FAIL async_data got dd=%h hr=%h ma=%h wd=%h want all 0", disp_data, host_rdata, mem_addr, mem_wdata);
        end
        $display("async reset: outputs checked");
        step();
        host_req = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (host_ack !== 1'b0 || clr_busy !== 1'b0 || mem_we !== 1'b0) begin
                failures++; $display("FAIL post_reset cycle %0d got ack=%b busy=%b we=%b want 0", i, host_ack, clr_busy, mem_we);
            end
            $display("post reset cycle %0d: ack=%b busy=%b", i, host_ack, clr_busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        disp_req = 1'b0; disp_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        clr_start = 1'b0; clr_value = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        for (int a = 0; a < 8; a++) begin
            ld_en = 1'b1; ld_addr = 10'(a); ld_data = 8'(a) ^ 8'h5A;
            step();
        end
        ld_en = 1'b0;
        test_reset();
        reset = 1'b0;
        step();
        test_display_burst();
        test_display_pattern();
        test_host_rw();
        test_starve();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
